cpu_sequencer: RTL and testbench

- Upstream timing and instruction-capture stage for the CPU control decoder.
- Generates the micro-cycle count that the decoder consumes.
- Latches the fetched opcode and the zero flag, and freezes the machine on halt.
- Takes the decoder's current state code back as feedback to decide the next cycle.

---
 rtl/cpu_sequencer_pkg.sv | 44 ++++
 rtl/cpu_sequencer_if.sv | 33 +++
 rtl/cpu_sequencer.sv | 100 ++++++++++
 tb/tb_cpu_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
// Shared definitions for the CPU sequencer and the control decoder:
//   - state_t     : 4-bit STATE_* codes produced by the decoder
//   - OP_*        : 4-bit opcode constants (upper nibble of the instruction)
//   - DEF_CYCLE_W / DEF_CYCLE_MAX : default micro-cycle counter geometry
//   - captures_zero() : states on which the ALU zero flag is latched
package cpu_sequencer_pkg;

  localparam int DEF_CYCLE_W   = 4;
  localparam int DEF_CYCLE_MAX = 6;

  typedef enum logic [3:0] {
    STATE_FETCH_PC   = 4'd0,
    STATE_FETCH_INST = 4'd1,
    STATE_HALT       = 4'd2,
    STATE_OUT_A      = 4'd3,
    STATE_NEXT       = 4'd4,
    STATE_JUMP       = 4'd5,
    STATE_SKIP_JUMP  = 4'd6,
    STATE_LOAD_ADDR  = 4'd7,
    STATE_RAM_A      = 4'd8,
    STATE_RAM_B      = 4'd9,
    STATE_STORE_A    = 4'd10,
    STATE_ADD        = 4'd11,
    STATE_SUB        = 4'd12
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // States whose ALU result is meaningful for the zero flag.
  function automatic logic captures_zero(input state_t s);
    return (s == STATE_ADD) || (s == STATE_SUB) || (s == STATE_RAM_A);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
// Bundle between the control decoder (master) and the sequencer (slave).
//   master drives : state, bus, alu_zero, step
//   slave drives  : cycle, opcode, eq_zero, halted, seq_err
// Signalling: there is no valid/ready pair on this link. Every input is
// sampled on each rising clk edge and every output is a register, so the
// decoder sees a new value exactly one clock after the edge producing it.
interface cpu_sequencer_if #(
  parameter int CYCLE_W = cpu_sequencer_pkg::DEF_CYCLE_W
);
  import cpu_sequencer_pkg::*;

  state_t             state;
  logic [7:0]         bus;
  logic               alu_zero;
  logic               step;
  logic [CYCLE_W-1:0] cycle;
  logic [3:0]         opcode;
  logic               eq_zero;
  logic               halted;
  logic               seq_err;

  modport master (
    output state, bus, alu_zero, step,
    input  cycle, opcode, eq_zero, halted, seq_err
  );

  modport slave (
    input  state, bus, alu_zero, step,
    output cycle, opcode, eq_zero, halted, seq_err
  );

endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Micro-cycle counter and instruction-capture stage ahead of the control
// decoder. Counts micro-cycles, resets the count on STATE_NEXT, flags an
// overrun past CYCLE_MAX, latches the opcode nibble and the zero flag, and
// freezes on STATE_HALT until reset.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   seq   : cpu_sequencer_if.slave (state/bus/alu_zero/step in,
//           cycle/opcode/eq_zero/halted/seq_err out)
// Optional build macro SEQ_SINGLE_STEP_EN: when defined, every update is
// gated by the rising edge of seq.step; otherwise step is ignored.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CYCLE_W   = DEF_CYCLE_W,
  parameter int CYCLE_MAX = DEF_CYCLE_MAX
) (
  input  logic           clk,
  input  logic           reset,
  cpu_sequencer_if.slave seq
);

  localparam logic [CYCLE_W-1:0] CYC_LAST = CYCLE_W'(CYCLE_MAX);

  logic [CYCLE_W-1:0] cycle_r, cycle_nxt;
  logic [3:0]         opcode_r, opcode_nxt;
  logic               zero_r, zero_nxt;
  logic               halted_r, halted_nxt;
  logic               err_r, err_nxt;
  logic               adv_en;

`ifdef SEQ_SINGLE_STEP_EN
  // One-register edge detector: a single advance per step press.
  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= seq.step;
  end

  assign adv_en = seq.step & ~step_q;

  logic unused_bits;
  assign unused_bits = ^seq.bus[3:0];
`else
  assign adv_en = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{seq.bus[3:0], seq.step};
`endif

  // Next-value logic. Halt wins over the counter rules, and a halted
  // machine holds every register; opcode and zero captures are independent
  // of which counter rule fires.
  always_comb begin
    cycle_nxt  = cycle_r;
    opcode_nxt = opcode_r;
    zero_nxt   = zero_r;
    halted_nxt = halted_r;
    err_nxt    = err_r;
    if (adv_en && !halted_r) begin
      if (seq.state == STATE_HALT) begin
        halted_nxt = 1'b1;
      end else if (seq.state == STATE_NEXT) begin
        cycle_nxt = '0;
      end else if (cycle_r == CYC_LAST) begin
        cycle_nxt = '0;
        err_nxt   = 1'b1;
      end else begin
        cycle_nxt = cycle_r + 1'b1;
      end
      if (seq.state == STATE_FETCH_INST) opcode_nxt = seq.bus[7:4];
      if (captures_zero(seq.state))      zero_nxt   = seq.alu_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r  <= '0;
      opcode_r <= 4'h0;
      zero_r   <= 1'b0;
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      cycle_r  <= cycle_nxt;
      opcode_r <= opcode_nxt;
      zero_r   <= zero_nxt;
      halted_r <= halted_nxt;
      err_r    <= err_nxt;
    end
  end

  assign seq.cycle   = cycle_r;
  assign seq.opcode  = opcode_r;
  assign seq.eq_zero = zero_r;
  assign seq.halted  = halted_r;
  assign seq.seq_err = err_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Scoreboarded bench for cpu_sequencer. Inputs change on the falling edge;
// the reference model predicts the register contents after the following
// rising edge and queues them; the monitor compares 1 time unit after each
// rising edge. Honours SEQ_SINGLE_STEP_EN the same way the design does.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int CW    = 4;
  localparam int CM    = 6;
  localparam int EXP_W = CW + 4 + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.CYCLE_W(CW)) sif ();

  cpu_sequencer #(.CYCLE_W(CW), .CYCLE_MAX(CM)) dut (
    .clk   (clk),
    .reset (reset),
    .seq   (sif.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int       m_cycle;
  bit [3:0] m_op;
  bit       m_z, m_halt, m_err, m_step_prev;

  task automatic model_edge(input bit rst, input state_t st, input logic [7:0] b,
                            input bit az, input bit stp);
    bit en;
    if (rst) begin
      m_cycle = 0; m_op = 0; m_z = 0; m_halt = 0; m_err = 0; m_step_prev = 0;
      return;
    end
`ifdef SEQ_SINGLE_STEP_EN
    en = stp && !m_step_prev;
`else
    en = 1'b1;
`endif
    m_step_prev = stp;
    if (!en || m_halt) return;
    if (st == STATE_HALT)      m_halt = 1;
    else if (st == STATE_NEXT) m_cycle = 0;
    else begin
      m_cycle = m_cycle + 1;
      if (m_cycle > CM) begin
        m_cycle = 0;
        m_err   = 1;
      end
    end
    if (st == STATE_FETCH_INST) m_op = b[7:4];
    if (st == STATE_ADD || st == STATE_SUB || st == STATE_RAM_A) m_z = az;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rst, input state_t st, input logic [7:0] b,
                       input bit az, input bit stp);
    @(negedge clk);
    reset        = rst;
    sif.state    = st;
    sif.bus      = b;
    sif.alu_zero = az;
    sif.step     = stp;
    model_edge(rst, st, b, az, stp);
    exp_q.push_back({CW'(m_cycle), m_op, m_z, m_halt, m_err});
  endtask

  // Toggles step on every call so directed sequences also advance (every
  // other edge) in the single-step build; step is ignored otherwise.
  bit auto_step = 0;
  task automatic drv(input bit rst, input state_t st, input logic [7:0] b, input bit az);
    auto_step = ~auto_step;
    drive(rst, st, b, az, auto_step);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EXP_W-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {sif.cycle, sif.opcode, sif.eq_zero, sif.halted, sif.seq_err};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL sb_out @%0t: got cycle=%0d opcode=%h eq_zero=%b halted=%b seq_err=%b, expected cycle=%0d opcode=%h eq_zero=%b halted=%b seq_err=%b",
                 $time, a[EXP_W-1:7], a[6:3], a[2], a[1], a[0],
                 e[EXP_W-1:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  state_t st_tbl[13] = '{STATE_FETCH_PC, STATE_FETCH_INST, STATE_HALT, STATE_OUT_A,
                         STATE_NEXT, STATE_JUMP, STATE_SKIP_JUMP, STATE_LOAD_ADDR,
                         STATE_RAM_A, STATE_RAM_B, STATE_STORE_A, STATE_ADD, STATE_SUB};

  initial begin
    state_t st;
    reset        = 1'b1;
    sif.state    = STATE_FETCH_PC;
    sif.bus      = 8'h00;
    sif.alu_zero = 1'b0;
    sif.step     = 1'b0;
    model_edge(1'b1, STATE_FETCH_PC, 8'h00, 1'b0, 1'b0);

    // Reset held two clocks, then free counting.
    drv(1, STATE_FETCH_PC, 8'h00, 0);
    drv(1, STATE_FETCH_PC, 8'h00, 0);
    repeat (3) drv(0, STATE_FETCH_PC, 8'h00, 0);

    // Fetch and early STATE_NEXT.
    drv(1, STATE_FETCH_PC, 8'h00, 0);
    drv(0, STATE_FETCH_PC, 8'h00, 0);
    drv(0, STATE_FETCH_INST, 8'hA5, 0);
    drv(0, STATE_OUT_A, 8'h00, 0);
    drv(0, STATE_OUT_A, 8'h00, 0);
    drv(0, STATE_NEXT, 8'h00, 0);
    drv(0, STATE_FETCH_PC, 8'h00, 0);

    // Zero flag capture and hold.
    drv(0, STATE_ADD, 8'h00, 1);
    drv(0, STATE_LOAD_ADDR, 8'h00, 0);
    drv(0, STATE_SUB, 8'h00, 0);
    drv(0, STATE_RAM_A, 8'h00, 1);
    drv(0, STATE_NEXT, 8'h00, 0);

    // Halt: frozen despite NEXT / FETCH_INST, then cleared by reset.
    drv(1, STATE_FETCH_PC, 8'h00, 0);
    drv(0, STATE_FETCH_PC, 8'h00, 0);
    drv(0, STATE_FETCH_PC, 8'h00, 0);
    drv(0, STATE_HALT, 8'h00, 0);
    for (int i = 0; i < 10; i++)
      drv(0, (i % 2) ? STATE_NEXT : STATE_FETCH_INST, 8'hFF, 1);
    drv(1, STATE_FETCH_PC, 8'h00, 0);

    // Overrun: no STATE_NEXT, wraps and stays flagged until reset.
    repeat (12) drv(0, STATE_FETCH_PC, 8'h00, 0);
    drv(0, STATE_NEXT, 8'h00, 0);
    drv(0, STATE_FETCH_PC, 8'h00, 0);
    drv(1, STATE_FETCH_PC, 8'h00, 0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: idle, three pulses, then a long press.
    repeat (5) drive(0, STATE_FETCH_PC, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, STATE_FETCH_PC, 8'h00, 0, 1);
      drive(0, STATE_FETCH_PC, 8'h00, 0, 0);
    end
    repeat (4) drive(0, STATE_FETCH_PC, 8'h00, 0, 1);
    drive(0, STATE_FETCH_PC, 8'h00, 0, 0);
`endif

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)       st = STATE_HALT;
      else if (r < 15) st = STATE_NEXT;
      else             st = st_tbl[$urandom_range(0, 12)];
      drive(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0, st,
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    // Drain: every queued expectation must have been consumed.
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
